// File: rtl/mp8085_ctrl_seq.sv
// Machine-cycle / T-state sequencer for the 8085-style core: steps each
// instruction through its bus cycles and decodes datapath and bus strobes.
module mp8085_ctrl_seq #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir,
    input  logic       mem_ready,
    output logic       ale,
    output logic       addr_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       z_load,
    output logic       w_load,
    output logic       pc_load_wz,
    output logic       acc_load,
    output logic       acc_src,
    output logic [2:0] mcycle,
    output logic [2:0] tstate,
    output logic       halted,
    output logic       illegal,
    output logic       bus_err
);

    typedef enum logic [2:0] {
        TS_HALT = 3'd0,
        TS_T1   = 3'd1,
        TS_T2   = 3'd2,
        TS_T3   = 3'd3,
        TS_T4   = 3'd4,
        TS_TW   = 3'd5
    } tstate_e;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MVI_A = 8'h3E;
    localparam logic [7:0] OP_LDA   = 8'h3A;
    localparam logic [7:0] OP_STA   = 8'h32;
    localparam logic [7:0] OP_JMP   = 8'hC3;
    localparam logic [7:0] OP_HLT   = 8'h76;
    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    localparam logic [2:0] MC_NONE = 3'd0;
    localparam logic [2:0] MC_M1   = 3'd1;
    localparam logic [2:0] MC_M2   = 3'd2;
    localparam logic [2:0] MC_M3   = 3'd3;
    localparam logic [2:0] MC_M4   = 3'd4;

    tstate_e    ts_r;
    logic [2:0] mc_r;
    logic [7:0] wait_cnt_r;
    logic       halted_r;
    logic       bus_err_r;

    logic is_nop_s;
    logic is_add_s;
    logic is_mvi_s;
    logic is_lda_s;
    logic is_sta_s;
    logic is_jmp_s;
    logic is_hlt_s;
    logic is_wz_op_s;
    logic is_legal_s;

    // Opcode classification; only meaningful from T4 of M1 onward.
    always_comb begin
        is_nop_s   = (ir == OP_NOP);
        is_add_s   = (ir[7:3] == 5'b10000);
        is_mvi_s   = (ir == OP_MVI_A);
        is_lda_s   = (ir == OP_LDA);
        is_sta_s   = (ir == OP_STA);
        is_jmp_s   = (ir == OP_JMP);
        is_hlt_s   = (ir == OP_HLT);
        is_wz_op_s = is_lda_s | is_sta_s | is_jmp_s;
        is_legal_s = is_nop_s | is_add_s | is_mvi_s | is_wz_op_s | is_hlt_s;
    end

    // Machine-cycle / T-state sequencer with wait-state timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_r       <= TS_T1;
            mc_r       <= MC_M1;
            wait_cnt_r <= 8'd0;
            halted_r   <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            case (ts_r)
                TS_T1: begin
                    ts_r       <= TS_T2;
                    wait_cnt_r <= 8'd0;
                end
                TS_T2, TS_TW: begin
                    if (mem_ready) begin
                        ts_r <= TS_T3;
                    end else if ((ts_r == TS_TW) && (wait_cnt_r >= WAIT_LIMIT)) begin
                        ts_r      <= TS_HALT;
                        mc_r      <= MC_NONE;
                        halted_r  <= 1'b1;
                        bus_err_r <= 1'b1;
                    end else begin
                        ts_r       <= TS_TW;
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                TS_T3: begin
                    if ((mc_r == MC_M1) || ((mc_r == MC_M3) && is_jmp_s)) begin
                        ts_r <= TS_T4;
                    end else begin
                        ts_r <= TS_T1;
                        case (mc_r)
                            MC_M2:   mc_r <= is_mvi_s ? MC_M1 : MC_M3;
                            MC_M3:   mc_r <= MC_M4;
                            default: mc_r <= MC_M1;
                        endcase
                    end
                end
                TS_T4: begin
                    if ((mc_r == MC_M1) && is_hlt_s) begin
                        ts_r     <= TS_HALT;
                        mc_r     <= MC_NONE;
                        halted_r <= 1'b1;
                    end else if ((mc_r == MC_M1) && (is_mvi_s || is_wz_op_s)) begin
                        ts_r <= TS_T1;
                        mc_r <= MC_M2;
                    end else begin
                        ts_r <= TS_T1;
                        mc_r <= MC_M1;
                    end
                end
                TS_HALT: begin
                    ts_r <= TS_HALT;
                    mc_r <= MC_NONE;
                end
                default: begin
                    ts_r <= TS_T1;
                    mc_r <= MC_M1;
                end
            endcase
        end
    end

    logic bus_active_s;
    logic m4_write_s;

    // Strobe decode from the registered state (plus IR, which is itself a
    // register); mem_ready never reaches an output combinationally.
    always_comb begin
        bus_active_s = (ts_r == TS_T2) || (ts_r == TS_TW) || (ts_r == TS_T3);
        m4_write_s   = (mc_r == MC_M4) && is_sta_s;

        ale        = (ts_r == TS_T1);
        addr_sel   = (mc_r == MC_M4);
        mem_rd     = bus_active_s && !m4_write_s;
        mem_wr     = bus_active_s && m4_write_s;
        ir_load    = (mc_r == MC_M1) && (ts_r == TS_T3);
        pc_inc     = (ts_r == TS_T3) && ((mc_r == MC_M1) || (mc_r == MC_M2) || (mc_r == MC_M3));
        z_load     = (mc_r == MC_M2) && (ts_r == TS_T3) && is_wz_op_s;
        w_load     = (mc_r == MC_M3) && (ts_r == TS_T3) && is_wz_op_s;
        pc_load_wz = (mc_r == MC_M3) && (ts_r == TS_T4) && is_jmp_s;
        acc_src    = (mc_r == MC_M1) && (ts_r == TS_T4) && is_add_s;
        acc_load   = acc_src
                   || ((mc_r == MC_M2) && (ts_r == TS_T3) && is_mvi_s)
                   || ((mc_r == MC_M4) && (ts_r == TS_T3) && is_lda_s);
        illegal    = (mc_r == MC_M1) && (ts_r == TS_T4) && !is_legal_s;
        mcycle     = mc_r;
        tstate     = ts_r;
        halted     = halted_r;
        bus_err    = bus_err_r;
    end

endmodule

// File: doc/mp8085_ctrl_seq.md
Name: mp8085_ctrl_seq

Overview:
- Machine-cycle / T-state control sequencer for the 8085-style core.
- Decodes the instruction register and steps each instruction through opcode fetch, operand read, memory read/write and execute cycles.
- Drives the datapath load/select strobes and the memory bus strobes, inserting wait states while memory is not ready.
- Sits between the instruction register and the PC/WZ/accumulator datapath, beside the top-level core.

Parameters:
- WAIT_MAX, 15, maximum consecutive wait states per bus cycle before bus error (1..255).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- ir  input  8  instruction register contents; valid from T4 of M1 onward
- mem_ready  input  1  memory ready, sampled at end of T2 and of each TW
- ale  output  1  address latch enable, high in T1 only
- addr_sel  output  1  0 = address from PC, 1 = address from {W,Z}
- mem_rd  output  1  read strobe, high in T2, TW, T3 of read cycles
- mem_wr  output  1  write strobe, high in T2, TW, T3 of write cycles
- ir_load  output  1  load IR from data bus (T3 of M1)
- pc_inc  output  1  increment PC (T3 of every PC-addressed cycle)
- z_load  output  1  load Z from data bus
- w_load  output  1  load W from data bus
- pc_load_wz  output  1  PC <= {W,Z}
- acc_load  output  1  load accumulator
- acc_src  output  1  0 = data bus, 1 = ALU result
- mcycle  output  3  current machine cycle 1..4; 0 in HALT
- tstate  output  3  1..4 = T1..T4, 5 = TW, 0 in HALT
- halted  output  1  high while in HALT
- illegal  output  1  one-cycle pulse in T4 of M1 for an unsupported opcode
- bus_err  output  1  sticky; set on wait-state timeout

Behaviour:
- Reset: state = M1/T1. mcycle = 1, tstate = 1; halted = 0, bus_err = 0; all strobes 0 except ale = 1, because the M1/T1 decode is active in the first cycle after reset.
- Reset is sampled every cycle. It aborts any cycle, including wait states and HALT.
- All outputs are registered-state decodes; there is no combinational path from mem_ready to any output.
- Bus cycle sequence: T1 -> T2 -> (TW)* -> T3.
  - At end of T2 or TW: if mem_ready = 0, go to TW; otherwise go to T3.
  - The wait counter clears in T1.
  - If the TW count reaches WAIT_MAX with mem_ready still 0: set bus_err, go to HALT.
- M1 (opcode fetch): addr_sel = 0; read strobes; ir_load and pc_inc in T3; decode in T4. Every instruction's M1 lasts 4+ cycles.
- Supported opcodes (cycles with zero waits):
  - 00 NOP: M1 only; 4 cycles.
  - 80-87 ADD r: in T4, acc_load = 1, acc_src = 1; 4 cycles.
  - 3E MVI A: M2 read from PC; in T3, acc_load = 1, acc_src = 0, pc_inc = 1; 7 cycles.
  - 3A LDA: M2 PC read with z_load and pc_inc; M3 PC read with w_load and pc_inc; M4 read with addr_sel = 1 and acc_load (src 0) in T3; 13 cycles.
  - 32 STA: M2 and M3 as LDA; M4 write with addr_sel = 1, mem_wr in T2/TW/T3, no loads; 13 cycles.
  - C3 JMP: M2 and M3 as LDA; M3 then has a T4 with pc_load_wz = 1; 11 cycles.
  - 76 HLT: after T4, enter HALT. halted = 1, all strobes 0, no exit except reset.
  - Any other opcode: executes as NOP with illegal = 1 in T4.
- After an instruction's last cycle, the next state is M1/T1.
- mcycle and tstate always reflect the cycle currently being driven.
- mem_rd and mem_wr are never both high. ale is never high outside T1.

Test Plan:
- Reset, then NOP stream with mem_ready = 1 -> ale pulses every 4 cycles; ir_load and pc_inc each once per 4 cycles; tstate 1,2,3,4 repeating.
- MVI A (3E) with mem_ready = 1 -> 7 cycles; acc_load with acc_src = 0 and pc_inc both high in T3 of M2; mcycle goes 1 -> 2.
- LDA (3A) with mem_ready low for 2 cycles in M4 -> tstate 1,2,5,5,3 in M4; mem_rd high for 4 cycles; addr_sel = 1; 15 cycles total.
- STA (32) then JMP (C3) -> mem_wr high only in M4 of STA, never together with mem_rd; JMP gives pc_load_wz for exactly 1 cycle at M3/T4, then ale next cycle.
- HLT (76), then reset asserted 5 cycles later -> halted = 1 from the cycle after T4, no strobes; reset returns to M1/T1 with halted = 0.
- Timeout and illegal opcode:
  - Hold mem_ready = 0 with WAIT_MAX = 3 -> bus_err set after 3 TW cycles; HALT entered; bus_err held until reset.
  - Opcode 0xFF -> illegal pulses 1 cycle in T4; next cycle is M1/T1.
